// File: rtl/yuv_to_rgb_csc.sv
// YUV 4:4:4 to packed RGB colour-space converter.
// Reads Y/U/V words (two pixels each) from SRAM, converts the pixel pair and
// writes three packed RGB words back. Ten cycles per pixel pair.
module yuv_to_rgb_csc #(
    parameter logic [17:0] Y_BASE    = 18'd0,
    parameter logic [17:0] U_BASE    = 18'd38400,
    parameter logic [17:0] V_BASE    = 18'd76800,
    parameter logic [17:0] RGB_BASE  = 18'd146944,
    parameter int unsigned NUM_PAIRS = 38400
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned ST_W   = 4;

    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_PAIRS - 1);

    localparam logic [ST_W-1:0] S_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] S_RD_Y   = 4'd1;
    localparam logic [ST_W-1:0] S_RD_U   = 4'd2;
    localparam logic [ST_W-1:0] S_RD_V   = 4'd3;
    localparam logic [ST_W-1:0] S_LAT0   = 4'd4;
    localparam logic [ST_W-1:0] S_LAT1   = 4'd5;
    localparam logic [ST_W-1:0] S_CALC_E = 4'd6;
    localparam logic [ST_W-1:0] S_CALC_O = 4'd7;
    localparam logic [ST_W-1:0] S_WR0    = 4'd8;
    localparam logic [ST_W-1:0] S_WR1    = 4'd9;
    localparam logic [ST_W-1:0] S_WR2    = 4'd10;
    localparam logic [ST_W-1:0] S_DONE   = 4'd11;

    // Saturate a signed result to the 0..255 pixel range.
    function automatic logic [7:0] clip8(input int val);
        if (val < 0) begin
            return 8'd0;
        end else if (val > 255) begin
            return 8'd255;
        end
        return 8'(val);
    endfunction

    // Fixed-point (16 fractional bits) BT.601 conversion of one pixel, {R,G,B}.
    function automatic logic [PIX_W-1:0] csc(input logic [7:0] y8,
                                             input logic [7:0] u8,
                                             input logic [7:0] v8);
        int y;
        int u;
        int v;
        int r;
        int g;
        int b;
        y = int'({24'd0, y8}) - 16;
        u = int'({24'd0, u8}) - 128;
        v = int'({24'd0, v8}) - 128;
        r = (76284 * y + 104595 * v) >>> 16;
        g = (76284 * y - 25624 * u - 53281 * v) >>> 16;
        b = (76284 * y + 132251 * u) >>> 16;
        return {clip8(r), clip8(g), clip8(b)};
    endfunction

    logic [ST_W-1:0]   state_q,    state_d;
    logic [ADDR_W-1:0] pair_idx_q, pair_idx_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DATA_W-1:0] y_q,        y_d;
    logic [DATA_W-1:0] u_q,        u_d;
    logic [DATA_W-1:0] v_q,        v_d;
    logic [PIX_W-1:0]  pix_e_q,    pix_e_d;
    logic [PIX_W-1:0]  pix_o_q,    pix_o_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              we_n_q,     we_n_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // State and registered outputs; async reset also drops an in-flight write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            pair_idx_q <= '0;
            wr_ptr_q   <= RGB_BASE;
            y_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
            pix_e_q    <= '0;
            pix_o_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pair_idx_q <= pair_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            y_q        <= y_d;
            u_q        <= u_d;
            v_q        <= v_d;
            pix_e_q    <= pix_e_d;
            pix_o_q    <= pix_o_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state; SRAM controls are set for the state being entered.
    always_comb begin
        state_d    = state_q;
        pair_idx_d = pair_idx_q;
        wr_ptr_d   = wr_ptr_q;
        y_d        = y_q;
        u_d        = u_q;
        v_d        = v_q;
        pix_e_d    = pix_e_q;
        pix_o_d    = pix_o_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_n_d     = 1'b1;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RD_Y;
                    busy_d  = 1'b1;
                    addr_d  = Y_BASE + pair_idx_q;
                end
            end
            S_RD_Y: begin
                state_d = S_RD_U;
                addr_d  = U_BASE + pair_idx_q;
            end
            S_RD_U: begin
                state_d = S_RD_V;
                addr_d  = V_BASE + pair_idx_q;
            end
            S_RD_V: begin
                state_d = S_LAT0;
                y_d     = SRAM_read_data;
            end
            S_LAT0: begin
                state_d = S_LAT1;
                u_d     = SRAM_read_data;
            end
            S_LAT1: begin
                state_d = S_CALC_E;
                v_d     = SRAM_read_data;
            end
            S_CALC_E: begin
                state_d = S_CALC_O;
                pix_e_d = csc(y_q[15:8], u_q[15:8], v_q[15:8]);
            end
            S_CALC_O: begin
                state_d = S_WR0;
                pix_o_d = csc(y_q[7:0], u_q[7:0], v_q[7:0]);
                we_n_d  = 1'b0;
                addr_d  = wr_ptr_q;
                wdata_d = {pix_e_q[23:16], pix_e_q[15:8]};
            end
            S_WR0: begin
                state_d = S_WR1;
                we_n_d  = 1'b0;
                addr_d  = wr_ptr_q + 18'd1;
                wdata_d = {pix_e_q[7:0], pix_o_q[23:16]};
            end
            S_WR1: begin
                state_d = S_WR2;
                we_n_d  = 1'b0;
                addr_d  = wr_ptr_q + 18'd2;
                wdata_d = {pix_o_q[15:8], pix_o_q[7:0]};
            end
            S_WR2: begin
                wr_ptr_d = wr_ptr_q + 18'd3;
                if (pair_idx_q == LAST_PAIR) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_RD_Y;
                    pair_idx_d = pair_idx_q + 18'd1;
                    addr_d     = Y_BASE + pair_idx_q + 18'd1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                pair_idx_d = '0;
                wr_ptr_d   = RGB_BASE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = busy_q;
    assign Done            = done_q;

endmodule

// File: tb/tb_yuv_to_rgb_csc.sv
// Scoreboard bench for yuv_to_rgb_csc with a two-pair conversion run.
module tb_yuv_to_rgb_csc;

    localparam int          NUM_PAIRS = 2;
    localparam logic [17:0] Y_BASE    = 18'd0;
    localparam logic [17:0] U_BASE    = 18'd38400;
    localparam logic [17:0] V_BASE    = 18'd76800;
    localparam logic [17:0] RGB_BASE  = 18'd146944;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Busy;
    logic        Done;

    bit   [15:0] mem [int];
    logic [15:0] rd_p1;
    logic [33:0] exp_q [$];
    logic [33:0] mon_exp;
    int          checks = 0;
    int          errors = 0;

    yuv_to_rgb_csc #(
        .Y_BASE   (Y_BASE),
        .U_BASE   (U_BASE),
        .V_BASE   (V_BASE),
        .RGB_BASE (RGB_BASE),
        .NUM_PAIRS(NUM_PAIRS)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #5 Clock = ~Clock;

    // SRAM with two-cycle read latency.
    always @(posedge Clock) begin
        rd_p1          <= mem.exists(int'(SRAM_address)) ? mem[int'(SRAM_address)] : 16'h0000;
        SRAM_read_data <= rd_p1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is popped against the expected queue.
    always @(negedge Clock) begin
        if (Reset === 1'b0 && SRAM_we_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr %0h data %0h expected no write",
                         SRAM_address, SRAM_write_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sram_write", {30'd0, SRAM_address, SRAM_write_data}, {30'd0, mon_exp});
            end
        end
    end

    task automatic load_pair(input int idx, input logic [15:0] y, input logic [15:0] u,
                             input logic [15:0] v);
        mem[int'(Y_BASE) + idx] = y;
        mem[int'(U_BASE) + idx] = u;
        mem[int'(V_BASE) + idx] = v;
    endtask

    task automatic expect_word(input int idx, input int k, input logic [15:0] w);
        exp_q.push_back({18'(int'(RGB_BASE) + 3 * idx + k), w});
    endtask

    task automatic expect_pair(input int idx, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2);
        expect_word(idx, 0, w0);
        expect_word(idx, 1, w1);
        expect_word(idx, 2, w2);
    endtask

    // Leaves the caller #1 into cycle 1 (first cycle after the sampling edge).
    task automatic pulse_start();
        @(posedge Clock);
        #1 Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (Done === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge Clock);
            #1;
        end
        check("done_seen", 64'(seen), 64'd1);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_addr",  64'(SRAM_address),    64'd0);
        check("rst_wdata", 64'(SRAM_write_data), 64'd0);
        check("rst_we_n",  64'(SRAM_we_n),       64'd1);
        check("rst_busy",  64'(Busy),            64'd0);
        check("rst_done",  64'(Done),            64'd0);
        @(posedge Clock);
        #1 Reset = 1'b0;

        // Black level and near-white greys.
        load_pair(0, 16'h1010, 16'h8080, 16'h8080);
        load_pair(1, 16'hEBEB, 16'h8080, 16'h8080);
        expect_pair(0, 16'h0000, 16'h0000, 16'h0000);
        expect_pair(1, 16'hFEFE, 16'hFEFE, 16'hFEFE);
        pulse_start();
        wait_done(40);
        check("queue_a", 64'(exp_q.size()), 64'd0);

        // Saturating chroma, both clip directions.
        load_pair(0, 16'hFF00, 16'h0080, 16'hFF80);
        load_pair(1, 16'h8080, 16'hFF00, 16'h8080);
        expect_pair(0, 16'hFFE0, 16'h1300, 16'h0000);
        expect_pair(1, 16'h8250, 16'hFF82, 16'hB400);
        pulse_start();
        wait_done(40);
        check("queue_b", 64'(exp_q.size()), 64'd0);

        // Cycle-exact Busy/Done; Start while busy and in DONE is ignored.
        load_pair(0, 16'h10EB, 16'h8080, 16'h8080);
        expect_pair(0, 16'h0000, 16'h00FE, 16'hFEFE);
        expect_pair(1, 16'h8250, 16'hFF82, 16'hB400);
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            check($sformatf("busy_c%0d", c), 64'(Busy), (c <= 20) ? 64'd1 : 64'd0);
            check($sformatf("done_c%0d", c), 64'(Done), (c == 21) ? 64'd1 : 64'd0);
            if (c == 5 || c == 21) Start = 1'b1;
            if (c == 6 || c == 22) Start = 1'b0;
            @(posedge Clock);
            #1;
        end
        check("queue_c", 64'(exp_q.size()), 64'd0);

        // Reset during the second write of pair 0.
        load_pair(0, 16'hFF00, 16'h0080, 16'hFF80);
        expect_word(0, 0, 16'hFFE0);
        expect_word(0, 1, 16'h1300);
        pulse_start();
        for (int c = 1; c < 9; c++) begin
            @(posedge Clock);
            #1;
        end
        @(negedge Clock);
        #1 Reset = 1'b1;
        #1;
        check("midrst_we_n", 64'(SRAM_we_n),    64'd1);
        check("midrst_busy", 64'(Busy),         64'd0);
        check("midrst_done", 64'(Done),         64'd0);
        check("midrst_addr", 64'(SRAM_address), 64'd0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        repeat (15) @(posedge Clock);
        #1;
        check("queue_rst", 64'(exp_q.size()), 64'd0);

        // Restart converts from pair 0 at the RGB base again.
        expect_pair(0, 16'hFFE0, 16'h1300, 16'h0000);
        expect_pair(1, 16'h8250, 16'hFF82, 16'hB400);
        pulse_start();
        wait_done(40);
        repeat (3) @(posedge Clock);
        #1;
        check("queue_d", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
